// File: rtl/fp_left_normalizer_if.sv
// Handshake/result bundle for the left normalizer.
// master drives start/exp_in/mant_in; slave returns status and results.
interface fp_left_normalizer_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 5
);
  logic              start;
  logic [EXP_W-1:0]  exp_in;
  logic [MANT_W-1:0] mant_in;
  logic              busy;
  logic              done;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_out;
  logic [CNT_W-1:0]  shift_cnt;
  logic              zero;
  logic              underflow;

  modport master (
    output start, exp_in, mant_in,
    input  busy, done, exp_out, mant_out,
    input  shift_cnt, zero, underflow
  );

  modport slave (
    input  start, exp_in, mant_in,
    output busy, done, exp_out, mant_out,
    output shift_cnt, zero, underflow
  );
endinterface

// File: rtl/fp_left_normalizer.sv
// Sequential left normalizer: one left shift + exp decrement per clock.
// Ports: clk, rst_n (async low), bus (slave): start/exp_in/mant_in in; busy/done/results out.
module fp_left_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_left_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [EXP_W-1:0]  exp_r, exp_n;
  logic [MANT_W-1:0] mant_r, mant_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [EXP_W-1:0]  exp_o, exp_on;
  logic [MANT_W-1:0] mant_o, mant_on;
  logic              zero_r, zero_n;
  logic              uf_r, uf_n;
  logic              busy_r, busy_n;
  logic              done_r, done_n;

  always_comb begin
    state_n = state;
    exp_n   = exp_r;
    mant_n  = mant_r;
    cnt_n   = cnt;
    exp_on  = exp_o;
    mant_on = mant_o;
    zero_n  = zero_r;
    uf_n    = uf_r;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          exp_n   = bus.exp_in;
          mant_n  = bus.mant_in;
          cnt_n   = '0;
          zero_n  = 1'b0;
          uf_n    = 1'b0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (mant_r == '0) begin
          zero_n  = 1'b1;
          exp_on  = '0;
          mant_on = '0;
          state_n = DONE;
        end else if (mant_r[MANT_W-1]) begin
          exp_on  = exp_r;
          mant_on = mant_r;
          state_n = DONE;
        end else if (exp_r <= EXP_W'(1)) begin
          // shifting further would take exp below the normal range
          uf_n    = 1'b1;
          exp_on  = '0;
          mant_on = mant_r;
          state_n = DONE;
        end else begin
          mant_n = mant_r << 1;
          exp_n  = exp_r - EXP_W'(1);
          cnt_n  = cnt + CNT_W'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      exp_r  <= '0;
      mant_r <= '0;
      cnt    <= '0;
      exp_o  <= '0;
      mant_o <= '0;
      zero_r <= 1'b0;
      uf_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      exp_r  <= exp_n;
      mant_r <= mant_n;
      cnt    <= cnt_n;
      exp_o  <= exp_on;
      mant_o <= mant_on;
      zero_r <= zero_n;
      uf_r   <= uf_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.exp_out   = exp_o;
  assign bus.mant_out  = mant_o;
  assign bus.shift_cnt = cnt;
  assign bus.zero      = zero_r;
  assign bus.underflow = uf_r;

endmodule

// File: tb/tb_fp_left_normalizer.sv
// Bench for fp_left_normalizer: vector table, corner sequences, random vs model.
// Drives the interface from initial blocks; samples 1 time unit after posedge.
module tb_fp_left_normalizer;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nbad;

  fp_left_normalizer_if #(.MANT_W(24), .EXP_W(8), .CNT_W(5)) bus ();

  fp_left_normalizer #(.MANT_W(24), .EXP_W(8), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  e;
    logic [23:0] m;
    logic [7:0]  eo;
    logic [23:0] mo;
    int          cnt;
    logic        z;
    logic        uf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // model: leading-zero count limited by how far exp may fall
  function automatic vec_t model(input logic [7:0] e, input logic [23:0] m);
    vec_t r;
    int lz;
    int maxs;
    r.e = e;
    r.m = m;
    r.z = 1'b0;
    r.uf = 1'b0;
    lz = 0;
    for (int b = 23; b >= 0; b--) begin
      if (m[b]) break;
      lz++;
    end
    maxs = (int'(e) > 1) ? int'(e) - 1 : 0;
    if (m == 0) begin
      r.z = 1'b1; r.eo = 0; r.mo = 0; r.cnt = 0;
    end else if (lz <= maxs) begin
      r.cnt = lz; r.eo = 8'(int'(e) - lz); r.mo = m << lz;
    end else begin
      r.uf = 1'b1; r.cnt = maxs; r.eo = 0; r.mo = m << maxs;
    end
    return r;
  endfunction

  // one operation; ign>0 pulses a stray start before edge E0+ign
  task automatic run(input string tag, input vec_t v, input int ign);
    int k;
    bus.exp_in  = v.e;
    bus.mant_in = v.m;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == ign) begin
        bus.start   = 1'b1;
        bus.exp_in  = 8'h80;
        bus.mant_in = 24'h800000;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        k = i;
        break;
      end
    end
    check({tag, "_lat"}, 32'(k), 32'(v.cnt + 1));
    check({tag, "_exp"}, 32'(bus.exp_out), 32'(v.eo));
    check({tag, "_mant"}, 32'(bus.mant_out), 32'(v.mo));
    check({tag, "_cnt"}, 32'(bus.shift_cnt), 32'(v.cnt));
    check({tag, "_zero"}, 32'(bus.zero), 32'(v.z));
    check({tag, "_uf"}, 32'(bus.underflow), 32'(v.uf));
    @(posedge clk);
    #1;
    check({tag, "_done1cyc"}, {30'd0, bus.done, bus.busy}, 32'd0);
    check({tag, "_hold"}, 32'(bus.mant_out), 32'(v.mo));
  endtask

  vec_t tbl[5];
  vec_t v;
  int   seen;

  initial begin
    ncmp = 0;
    nbad = 0;
    tbl[0] = '{8'h80, 24'h800000, 8'h80, 24'h800000, 0,  1'b0, 1'b0};
    tbl[1] = '{8'h85, 24'h000C00, 8'h79, 24'hC00000, 12, 1'b0, 1'b0};
    tbl[2] = '{8'h40, 24'h000000, 8'h00, 24'h000000, 0,  1'b1, 1'b0};
    tbl[3] = '{8'h03, 24'h010000, 8'h00, 24'h040000, 2,  1'b0, 1'b1};
    tbl[4] = '{8'hFE, 24'h000001, 8'hE7, 24'h800000, 23, 1'b0, 1'b0};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.exp_in  = '0;
    bus.mant_in = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", {bus.exp_out, bus.mant_out}, 32'd0);
    check("rst_flags", {bus.shift_cnt, bus.zero, bus.underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run($sformatf("vec%0d", i), tbl[i], 0);

    // stray start during a long run must not disturb it
    run("ignore", tbl[4], 5);

    // reset mid-operation
    bus.exp_in  = 8'hFE;
    bus.mant_in = 24'h000001;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_res", {bus.exp_out, bus.mant_out}, 32'd0);
    check("abort_flags", {bus.shift_cnt, bus.zero, bus.underflow, bus.done},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check("abort_nodone", 32'(seen), 32'd0);

    // back-to-back with start held high
    bus.exp_in  = 8'h80;
    bus.mant_in = 24'h800000;
    bus.start   = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b_done%0d", j), 32'(bus.done),
            32'((j % 3) == 1));
      check($sformatf("b2b_busy%0d", j), 32'(bus.busy),
            32'((j % 3) != 2));
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // random operations against the model
    for (int n = 0; n < 150; n++) begin
      logic [7:0]  e;
      logic [23:0] m;
      e = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 12));
      m = 24'($urandom) >> $urandom_range(0, 24);
      v = model(e, m);
      run($sformatf("rnd%0d", n), v, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
